matmul_loop_ctrl: RTL

MATMUL_LOOP_CTRL -- requirements
Module: matmul_loop_ctrl

---
 rtl/matmul_loop_ctrl_pkg.sv | 5 +
 rtl/matmul_loop_ctrl_if.sv | 21 ++
 rtl/matmul_loop_ctrl_mm_last_cmp.sv | 8 +
 rtl/matmul_loop_ctrl.sv | 56 +++++
 4 files changed

// File: rtl/matmul_loop_ctrl_pkg.sv
// matmul_loop_ctrl_pkg: shared state type and default index width for the matmul loop controller.
package matmul_loop_ctrl_pkg;
  localparam int DW_DEF = 8;
  typedef enum logic [2:0] {IDLE, INIT, MAC, WRITE, DONE} state_t;
endpackage

// File: rtl/matmul_loop_ctrl_if.sv
// matmul_loop_ctrl_if: control/status bundle between the loop controller and its index counters.
// Optional stall input exists only when MMCTRL_STALL_EN is defined.
interface matmul_loop_ctrl_if import matmul_loop_ctrl_pkg::*; #(parameter int DW = DW_DEF);
  logic start;
  logic [DW-1:0] dimM, dimN, dimP;
  logic [DW-1:0] cntI, cntJ, cntK;
  logic enI, zeroI, enJ, zeroJ, enK, zeroK;
  logic macEn, accClr, wrEn, busy, done;
`ifdef MMCTRL_STALL_EN
  logic stall;
  modport master (output start, dimM, dimN, dimP, cntI, cntJ, cntK, stall,
                  input enI, zeroI, enJ, zeroJ, enK, zeroK, macEn, accClr, wrEn, busy, done);
  modport slave (input start, dimM, dimN, dimP, cntI, cntJ, cntK, stall,
                 output enI, zeroI, enJ, zeroJ, enK, zeroK, macEn, accClr, wrEn, busy, done);
`else
  modport master (output start, dimM, dimN, dimP, cntI, cntJ, cntK,
                  input enI, zeroI, enJ, zeroJ, enK, zeroK, macEn, accClr, wrEn, busy, done);
  modport slave (input start, dimM, dimN, dimP, cntI, cntJ, cntK,
                 output enI, zeroI, enJ, zeroJ, enK, zeroK, macEn, accClr, wrEn, busy, done);
`endif
endinterface

// File: rtl/matmul_loop_ctrl_mm_last_cmp.sv
// mm_last_cmp: flags the final iteration of one loop (count == dim-1, wrapping in DW bits).
module mm_last_cmp import matmul_loop_ctrl_pkg::*; #(parameter int DW = DW_DEF) (
  input  logic [DW-1:0] cnt,
  input  logic [DW-1:0] dim,
  output logic          last
);
  assign last = cnt == (dim - DW'(1));
endmodule

// File: rtl/matmul_loop_ctrl.sv
// matmul_loop_ctrl: i/j/k loop sequencer for C = A*B driving external index counters.
// Define MMCTRL_STALL_EN to add a stall input that freezes the sequencer.
module matmul_loop_ctrl import matmul_loop_ctrl_pkg::*; #(parameter int DW = DW_DEF) (
  input logic clk,
  input logic rstN,
  matmul_loop_ctrl_if.slave bus
);
  state_t state;
  logic [DW-1:0] m, n, p;
  logic last_i, last_j, last_k, run, zero_dim, wr, init;
  mm_last_cmp #(.DW(DW)) u_cmp_i (.cnt(bus.cntI), .dim(m), .last(last_i));
  mm_last_cmp #(.DW(DW)) u_cmp_j (.cnt(bus.cntJ), .dim(n), .last(last_j));
  mm_last_cmp #(.DW(DW)) u_cmp_k (.cnt(bus.cntK), .dim(p), .last(last_k));
`ifdef MMCTRL_STALL_EN
  assign run = !bus.stall;
`else
  assign run = 1'b1;
`endif
  assign zero_dim = (bus.dimM == '0) || (bus.dimN == '0) || (bus.dimP == '0);
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      state <= IDLE;
      m <= '0;
      n <= '0;
      p <= '0;
    end else if (run) begin
      case (state)
        IDLE:
          if (bus.start) begin
            m <= bus.dimM;
            n <= bus.dimN;
            p <= bus.dimP;
            state <= zero_dim ? DONE : INIT;
          end
        INIT:    state <= MAC;
        MAC:     state <= last_k ? WRITE : MAC;
        WRITE:   state <= (last_j && last_i) ? DONE : MAC;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  // Strobes decode from state and counter values only; stall masks every strobe but busy.
  assign init       = run && state == INIT;
  assign wr         = run && state == WRITE;
  assign bus.macEn  = run && state == MAC;
  assign bus.enK    = bus.macEn;
  assign bus.zeroK  = init || wr;
  assign bus.accClr = init || wr;
  assign bus.wrEn   = wr;
  assign bus.enJ    = wr && !last_j;
  assign bus.zeroJ  = init || (wr && last_j);
  assign bus.enI    = wr && last_j && !last_i;
  assign bus.zeroI  = init || (wr && last_j && last_i);
  assign bus.done   = run && state == DONE;
  assign bus.busy   = state != IDLE;
endmodule
